// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and its datapath.
// The controller drives the controls every cycle, so there is no handshake: each cycle's outputs are valid for that cycle only.
interface multicycle_controller_if;
  logic [5:0] OpCode;
  logic [5:0] Funct;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ExtOp, LuiOp;
  logic [1:0] RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource, ALUOp;
  logic [2:0] state;
  logic       illegal;

  modport master (
    input  OpCode, Funct, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ExtOp, LuiOp,
    output RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource, ALUOp, state, illegal
  );

  modport slave (
    output OpCode, Funct, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ExtOp, LuiOp,
    input  RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource, ALUOp, state, illegal
  );
endinterface

// File: rtl/multicycle_controller.sv
// Five-state multicycle MIPS-style controller: IF, ID, EX, MEM, WB.
// The state register resets asynchronously; all controls are decoded combinationally and forced to zero while reset is high.
module multicycle_controller (
  input  logic                    clk,
  input  logic                    reset,
  multicycle_controller_if.master bus
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  typedef struct packed {
    logic       illegal;
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       ext_op;
    logic       lui_op;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
  } ctrl_t;

  state_t state_q, state_d;
  ctrl_t  ctrl_d, ctrl_o;

  logic is_rtype, is_j, is_jal, is_beq, is_lw, is_sw, is_ialu;
  logic is_jr, is_jalr, is_shift, is_legal;

  assign is_rtype = (bus.OpCode == 6'h00);
  assign is_j     = (bus.OpCode == 6'h02);
  assign is_jal   = (bus.OpCode == 6'h03);
  assign is_beq   = (bus.OpCode == 6'h04);
  assign is_lw    = (bus.OpCode == 6'h23);
  assign is_sw    = (bus.OpCode == 6'h2b);
  assign is_ialu  = (bus.OpCode inside {6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0f});
  assign is_jr    = is_rtype && (bus.Funct == 6'h08);
  assign is_jalr  = is_rtype && (bus.Funct == 6'h09);
  assign is_shift = bus.Funct inside {6'h00, 6'h02, 6'h03};
  assign is_legal = is_rtype || is_j || is_jal || is_beq || is_lw || is_sw || is_ialu;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IF;
    else       state_q <= state_d;
  end

  always_comb begin
    ctrl_d  = '0;
    state_d = S_IF;
    case (state_q)
      S_IF: begin
        ctrl_d.mem_read  = 1'b1;
        ctrl_d.alu_src_b = 2'b01;
        ctrl_d.ir_write  = bus.mem_ready;
        ctrl_d.pc_write  = bus.mem_ready;
        state_d          = bus.mem_ready ? S_ID : S_IF;
      end
      S_ID: begin
        // Speculatively compute the branch target into ALUOut.
        ctrl_d.alu_src_b = 2'b11;
        if (is_j || is_jal) begin
          ctrl_d.pc_write  = 1'b1;
          ctrl_d.pc_source = 2'b10;
          if (is_jal) begin
            ctrl_d.reg_write  = 1'b1;
            ctrl_d.reg_dst    = 2'b10;
            ctrl_d.mem_to_reg = 2'b10;
          end
          state_d = S_IF;
        end else if (is_jr || is_jalr) begin
          ctrl_d.pc_write  = 1'b1;
          ctrl_d.pc_source = 2'b11;
          if (is_jalr) begin
            ctrl_d.reg_write  = 1'b1;
            ctrl_d.reg_dst    = 2'b01;
            ctrl_d.mem_to_reg = 2'b10;
          end
          state_d = S_IF;
        end else if (!is_legal) begin
          ctrl_d.illegal = 1'b1;
          state_d        = S_IF;
        end else begin
          state_d = S_EX;
        end
      end
      S_EX: begin
        if (is_rtype) begin
          ctrl_d.alu_src_a = is_shift ? 2'b10 : 2'b01;
          ctrl_d.alu_op    = 2'b10;
          state_d          = S_WB;
        end else if (is_beq) begin
          ctrl_d.alu_src_a     = 2'b01;
          ctrl_d.alu_op        = 2'b01;
          ctrl_d.pc_write_cond = 1'b1;
          ctrl_d.pc_source     = 2'b01;
          state_d              = S_IF;
        end else if (is_lw || is_sw) begin
          ctrl_d.alu_src_a = 2'b01;
          ctrl_d.alu_src_b = 2'b10;
          ctrl_d.ext_op    = 1'b1;
          state_d          = S_MEM;
        end else if (is_ialu) begin
          ctrl_d.alu_src_a = 2'b01;
          ctrl_d.alu_src_b = 2'b10;
          ctrl_d.alu_op    = 2'b11;
          // andi/ori zero-extend; everything else sign-extends.
          ctrl_d.ext_op    = !(bus.OpCode inside {6'h0c, 6'h0d});
          ctrl_d.lui_op    = (bus.OpCode == 6'h0f);
          state_d          = S_WB;
        end
      end
      S_MEM: begin
        ctrl_d.iord      = 1'b1;
        ctrl_d.mem_read  = is_lw;
        ctrl_d.mem_write = is_sw;
        if (!bus.mem_ready)  state_d = S_MEM;
        else if (is_lw)      state_d = S_WB;
        else                 state_d = S_IF;
      end
      S_WB: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.reg_dst    = is_rtype ? 2'b01 : 2'b00;
        ctrl_d.mem_to_reg = is_lw ? 2'b01 : 2'b00;
      end
      default: state_d = S_IF;
    endcase
  end

  // Reset overrides everything, including the IF fetch controls.
  assign ctrl_o = reset ? '0 : ctrl_d;

  assign bus.state       = state_q;
  assign bus.illegal     = ctrl_o.illegal;
  assign bus.PCWrite     = ctrl_o.pc_write;
  assign bus.PCWriteCond = ctrl_o.pc_write_cond;
  assign bus.IorD        = ctrl_o.iord;
  assign bus.MemRead     = ctrl_o.mem_read;
  assign bus.MemWrite    = ctrl_o.mem_write;
  assign bus.IRWrite     = ctrl_o.ir_write;
  assign bus.RegWrite    = ctrl_o.reg_write;
  assign bus.ExtOp       = ctrl_o.ext_op;
  assign bus.LuiOp       = ctrl_o.lui_op;
  assign bus.RegDst      = ctrl_o.reg_dst;
  assign bus.MemtoReg    = ctrl_o.mem_to_reg;
  assign bus.ALUSrcA     = ctrl_o.alu_src_a;
  assign bus.ALUSrcB     = ctrl_o.alu_src_b;
  assign bus.PCSource    = ctrl_o.pc_source;
  assign bus.ALUOp       = ctrl_o.alu_op;

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have: clk  input  1  clock; all state updates on rising edge.
REQ-002 SHALL have: reset  input  1  reset, asynchronous, active-high; clock clk.
REQ-003 SHALL have: OpCode  input  6  opcode from instruction register.
REQ-004 SHALL have: Funct  input  6  function field from instruction register.
REQ-005 SHALL have: mem_ready  input  1  memory completes current access this cycle.
REQ-006 SHALL have: PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ExtOp, LuiOp  output  1 each  datapath controls.
REQ-007 SHALL have: RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource, ALUOp  output  2 each  datapath selects.
REQ-008 SHALL have: state  output  3  current state; illegal  output  1  unsupported-opcode pulse.

Function
REQ-009 SHALL implement states IF=0, ID=1, EX=2, MEM=3, WB=4; codes 5-7 SHALL go to IF next cycle.
REQ-010 All outputs SHALL be combinational from state, OpCode, Funct, mem_ready; unlisted enables 0, unlisted selects 00.
REQ-011 Selects: RegDst 00 rt/01 rd/10 $31; MemtoReg 00 ALUOut/01 MDR/10 PC; ALUSrcA 00 PC/01 A/10 shamt; ALUSrcB 00 B/01 const 4/10 ext imm/11 ext imm<<2; PCSource 00 ALU/01 ALUOut/10 jump target/11 rs; ALUOp 00 add/01 sub/10 funct/11 opcode.
REQ-012 IF: MemRead=1, IorD=0, ALUSrcA=00, ALUSrcB=01, PCSource=00; IRWrite=PCWrite=mem_ready; stay in IF while mem_ready=0, else go ID.
REQ-013 ID: ALUSrcA=00, ALUSrcB=11, ALUOp=00 (branch target into ALUOut).
REQ-014 ID, j(0x02): PCWrite=1, PCSource=10, then IF.
REQ-015 ID, jal(0x03): PCWrite=1, PCSource=10, RegWrite=1, RegDst=10, MemtoReg=10, then IF.
REQ-016 ID, R-type jr(funct 0x08): PCWrite=1, PCSource=11, then IF; jalr(0x09): additionally RegWrite=1, RegDst=01, MemtoReg=10.
REQ-017 ID, opcode not in {0x00,0x02,0x03,0x04,0x08,0x09,0x0a,0x0b,0x0c,0x0d,0x0f,0x23,0x2b}: illegal=1, no write enables, then IF; all other opcodes go EX.
REQ-018 EX, R-type: ALUSrcA=10 for funct 0x00/0x02/0x03 else 01, ALUSrcB=00, ALUOp=10, then WB.
REQ-019 EX, beq(0x04): ALUSrcA=01, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, then IF.
REQ-020 EX, lw/sw: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ExtOp=1, then MEM.
REQ-021 EX, I-type ALU (0x08-0x0d, 0x0f): ALUSrcA=01, ALUSrcB=10, ALUOp=11, ExtOp=0 for 0x0c/0x0d else 1, LuiOp=1 for 0x0f, then WB.
REQ-022 MEM: IorD=1; MemRead=1 for lw, MemWrite=1 for sw; stay while mem_ready=0; on mem_ready sw to IF, lw to WB.
REQ-023 WB: RegWrite=1; RegDst=01 for R-type else 00; MemtoReg=01 for lw else 00; then IF.
REQ-024 Latency: j/jal/jr/jalr 2 cycles, beq 3, R/I-ALU/sw 4, lw 5, each plus memory wait cycles.
REQ-025 OpCode/Funct changes outside IF/ID SHALL be ignored for transitions except via state decode already taken.

Reset
REQ-026 reset SHALL force state=IF immediately, independent of clk.
REQ-027 While reset=1 all 1-bit outputs SHALL be 0 and all selects 00, overriding REQ-012.
REQ-028 Reset mid-instruction (any state) SHALL abort it with no further write enable; first cycle after release is IF.

Verification
REQ-029 Reset, mem_ready=1, OpCode=0x23 -> states 0,1,2,3,4,0; WB: RegWrite=1, MemtoReg=01, RegDst=00.
REQ-030 IF with mem_ready=0 for 3 cycles -> state=0, IRWrite=0, PCWrite=0; 4th cycle mem_ready=1 -> IRWrite=PCWrite=1 for exactly that cycle.
REQ-031 OpCode=0x04 -> states 0,1,2,0; EX: PCWriteCond=1, PCSource=01, ALUOp=01.
REQ-032 OpCode=0x03 -> states 0,1,0; ID: PCWrite=1, RegWrite=1, RegDst=10, MemtoReg=10.
REQ-033 OpCode=0x3f -> illegal=1 in ID only, all write enables 0, next state 0.
REQ-034 OpCode=0x2b, reset asserted in MEM with mem_ready=0 -> MemWrite falls to 0 same cycle, state=0.
